// File: rtl/spi_master_tx.sv
// spi_master_tx: Mode-0 SPI master transmitter. It sends one DATA_WIDTH-bit word
// per SS-low frame, MSB first, with MOSI changing on SCLK falling edges.
// Optional feature macro: SPI_TX_FLUSH_CLK_EN. When defined, GAP starts with two
// SCLK pulses while SS is high, so the receiver can resynchronise its bit counter.
module spi_master_tx #(
  parameter int DATA_WIDTH = 32,
  parameter int CLK_DIV    = 4,
  parameter int SS_SETUP   = 2,
  parameter int SS_HOLD    = 2,
  parameter int GAP_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  SS,
  output logic                  SCLK,
  output logic                  MOSI
);

`ifdef SPI_TX_FLUSH_CLK_EN
  localparam int FLUSH_LEN = 4 * CLK_DIV;
`else
  localparam int FLUSH_LEN = 0;
`endif
  localparam int GAP_LEN = FLUSH_LEN + GAP_CYCLES;

  // One counter times every state, so it is sized for the longest state.
  localparam int MAX_A   = (2 * CLK_DIV > SS_SETUP) ? 2 * CLK_DIV : SS_SETUP;
  localparam int MAX_B   = (SS_HOLD > GAP_LEN) ? SS_HOLD : GAP_LEN;
  localparam int MAX_CNT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW      = $clog2(MAX_CNT + 1);
  localparam int BW      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CW-1:0] C_SETUP_LAST = CW'(SS_SETUP - 1);
  localparam logic [CW-1:0] C_HI_LAST    = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] C_LO_LAST    = CW'(2 * CLK_DIV - 1);
  localparam logic [CW-1:0] C_HOLD_LAST  = CW'(SS_HOLD - 1);
  localparam logic [CW-1:0] C_GAP_LAST   = CW'(GAP_LEN - 1);
  localparam logic [BW-1:0] C_BIT_LAST   = BW'(DATA_WIDTH - 1);
`ifdef SPI_TX_FLUSH_CLK_EN
  localparam logic [CW-1:0] C_FL_P1_END  = CW'(CLK_DIV);
  localparam logic [CW-1:0] C_FL_P2_BEG  = CW'(2 * CLK_DIV);
  localparam logic [CW-1:0] C_FL_P2_END  = CW'(3 * CLK_DIV);
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_SHIFT = 3'd2,
    S_HOLD  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic [BW-1:0]         r_bit;
  logic [DATA_WIDTH-1:0] r_sh;
  logic                  r_ss;
  logic                  r_sclk;
  logic                  r_ready;
  logic                  r_busy;
  logic                  r_done;
  logic [CW-1:0]         w_cnt_inc;

  assign w_cnt_inc = r_cnt + CW'(1);

  // MOSI is the shift-register MSB: loaded with the word, shifted on SCLK falls,
  // and cleared on entry to GAP so the pad idles low.
  assign MOSI     = r_sh[DATA_WIDTH-1];
  assign SS       = r_ss;
  assign SCLK     = r_sclk;
  assign tx_ready = r_ready;
  assign busy     = r_busy;
  assign done     = r_done;

  // Frame sequencer: state, counters, shift register and all pad/handshake outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_sh    <= '0;
      r_ss    <= 1'b1;
      r_sclk  <= 1'b0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (tx_valid && r_ready) begin
            r_sh    <= tx_data;
            r_ss    <= 1'b0;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_state <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (r_cnt == C_SETUP_LAST) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_sclk  <= 1'b1;
            r_state <= S_SHIFT;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_SHIFT: begin
          if (r_cnt == C_HI_LAST) begin
            // Falling edge: present the next bit unless this was the last one.
            r_sclk <= 1'b0;
            r_cnt  <= w_cnt_inc;
            if (r_bit != C_BIT_LAST) begin
              r_sh <= {r_sh[DATA_WIDTH-2:0], 1'b0};
            end
          end else if (r_cnt == C_LO_LAST) begin
            r_cnt <= '0;
            if (r_bit == C_BIT_LAST) begin
              r_state <= S_HOLD;
            end else begin
              r_bit  <= r_bit + BW'(1);
              r_sclk <= 1'b1;
            end
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_HOLD: begin
          if (r_cnt == C_HOLD_LAST) begin
            r_cnt   <= '0;
            r_ss    <= 1'b1;
            r_sh    <= '0;
            r_done  <= 1'b1;
            r_state <= S_GAP;
`ifdef SPI_TX_FLUSH_CLK_EN
            r_sclk  <= 1'b1;
`endif
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_GAP: begin
          if (r_cnt == C_GAP_LAST) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_sclk  <= 1'b0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= w_cnt_inc;
`ifdef SPI_TX_FLUSH_CLK_EN
            // Two flush pulses: high over counts [0,CLK_DIV) and [2*CLK_DIV,3*CLK_DIV).
            r_sclk <= (w_cnt_inc < C_FL_P1_END) ||
                      ((w_cnt_inc >= C_FL_P2_BEG) && (w_cnt_inc < C_FL_P2_END));
`endif
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_bit   <= '0;
          r_sh    <= '0;
          r_ss    <= 1'b1;
          r_sclk  <= 1'b0;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_tx.sv
`timescale 1ns/1ps
// Directed bench for spi_master_tx: a 32-bit CLK_DIV=2 instance and an 8-bit
// CLK_DIV=1 instance, observed by pad-level monitors sampling on the falling clk edge.
module tb_spi_master_tx;

`ifdef SPI_TX_FLUSH_CLK_EN
  localparam int GAP_A       = 12;  // 4*2 + 4
  localparam int GAP_B       = 8;   // 4*1 + 4
  localparam int FLUSH_RISES = 2;
`else
  localparam int GAP_A       = 4;
  localparam int GAP_B       = 4;
  localparam int FLUSH_RISES = 0;
`endif
  localparam int LEN_A   = 132;  // 2 + 2*2*32 + 2
  localparam int RISES_A = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] a_data = 32'h0;
  logic        a_valid = 1'b0;
  logic        a_ready, a_busy, a_done, a_ss, a_sclk, a_mosi;
  logic [7:0]  b_data = 8'h0;
  logic        b_valid = 1'b0;
  logic        b_ready, b_busy, b_done, b_ss, b_sclk, b_mosi;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  spi_master_tx #(.DATA_WIDTH(32), .CLK_DIV(2), .SS_SETUP(2), .SS_HOLD(2), .GAP_CYCLES(4)) u_a (
    .clk(clk), .reset(reset), .tx_data(a_data), .tx_valid(a_valid), .tx_ready(a_ready),
    .busy(a_busy), .done(a_done), .SS(a_ss), .SCLK(a_sclk), .MOSI(a_mosi));

  spi_master_tx #(.DATA_WIDTH(8), .CLK_DIV(1), .SS_SETUP(2), .SS_HOLD(2), .GAP_CYCLES(4)) u_b (
    .clk(clk), .reset(reset), .tx_data(b_data), .tx_valid(b_valid), .tx_ready(b_ready),
    .busy(b_busy), .done(b_done), .SS(b_ss), .SCLK(b_sclk), .MOSI(b_mosi));

  // Pad monitor for instance A.
  logic        a_pss = 1'b1, a_psclk = 1'b0;
  int          a_run_lo = 0, a_run_hi = 0, a_last_len = 0, a_prev_len = 0, a_last_gap = 0;
  int          a_rises = 0, a_rises_hi = 0, a_dones = 0, a_frames = 0, a_mosi_hi = 0, a_rdy_lo = 0;
  logic [31:0] a_sh = 32'h0, a_last_word = 32'h0, a_prev_word = 32'h0;

  always @(negedge clk) begin
    a_pss   <= a_ss;
    a_psclk <= a_sclk;
    if (a_ss) begin
      if (!a_pss) begin
        a_frames    <= a_frames + 1;
        a_prev_len  <= a_last_len;
        a_last_len  <= a_run_lo;
        a_prev_word <= a_last_word;
        a_last_word <= a_sh;
        a_run_hi    <= 1;
      end else begin
        a_run_hi <= a_run_hi + 1;
      end
      if (a_mosi) a_mosi_hi <= a_mosi_hi + 1;
    end else begin
      if (a_pss) begin
        a_last_gap <= a_run_hi;
        a_run_lo   <= 1;
        a_sh       <= 32'h0;
      end else begin
        a_run_lo <= a_run_lo + 1;
      end
      if (a_ready) a_rdy_lo <= a_rdy_lo + 1;
    end
    if (a_sclk && !a_psclk) begin
      if (a_ss) a_rises_hi <= a_rises_hi + 1;
      else begin
        a_rises <= a_rises + 1;
        a_sh    <= {a_sh[30:0], a_mosi};
      end
    end
    if (a_done) a_dones <= a_dones + 1;
  end

  // Pad monitor for instance B, including the spacing of in-frame SCLK rises.
  logic       b_pss = 1'b1, b_psclk = 1'b0;
  int         b_run_lo = 0, b_last_len = 0, b_rises = 0, b_dones = 0;
  int         b_since = 0, b_last_period = 0;
  logic [7:0] b_sh = 8'h0, b_last_word = 8'h0;

  always @(negedge clk) begin
    b_pss   <= b_ss;
    b_psclk <= b_sclk;
    b_since <= b_since + 1;
    if (b_ss) begin
      if (!b_pss) begin
        b_last_len  <= b_run_lo;
        b_last_word <= b_sh;
      end
    end else begin
      if (b_pss) begin
        b_run_lo <= 1;
        b_sh     <= 8'h0;
      end else begin
        b_run_lo <= b_run_lo + 1;
      end
    end
    if (b_sclk && !b_psclk && !b_ss) begin
      b_rises       <= b_rises + 1;
      b_sh          <= {b_sh[6:0], b_mosi};
      b_last_period <= b_since;
      b_since       <= 1;
    end
    if (b_done) b_dones <= b_dones + 1;
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Waits (bounded) for SS to rise, then counts GAP cycles until tx_ready returns.
  task automatic finish_frame_a(input string tag, output int gap);
    int n;
    n = 0;
    while (!a_ss && n < 600) begin @(negedge clk); n++; end
    check({tag, "_ss_rise"}, a_ss, 1);
    gap = 0;
    while (!a_ready && gap < 100) begin @(negedge clk); gap++; end
    check({tag, "_ready_back"}, a_ready, 1);
    @(negedge clk);
  endtask

  task automatic wait_ready_a(input string tag);
    int n;
    n = 0;
    while (!a_ready && n < 600) begin @(negedge clk); n++; end
    check({tag, "_ready_wait"}, a_ready, 1);
  endtask

  // Sends one word on A; late_data is driven onto tx_data right after acceptance.
  task automatic frame_a(input string tag, input logic [31:0] word, input logic [31:0] late_data,
                         input logic [31:0] exp_word);
    int d0, r0, h0, gap;
    @(negedge clk);
    wait_ready_a(tag);
    d0 = a_dones; r0 = a_rises; h0 = a_rises_hi;
    a_data = word; a_valid = 1'b1;
    @(posedge clk); #1;
    a_valid = 1'b0; a_data = late_data;
    check({tag, "_ss_fall_1cyc"}, a_ss, 0);
    @(negedge clk);
    finish_frame_a(tag, gap);
    check({tag, "_ss_len"}, a_last_len, LEN_A);
    check({tag, "_rises"}, a_rises - r0, RISES_A);
    check({tag, "_word"}, a_last_word, exp_word);
    check({tag, "_done"}, a_dones - d0, 1);
    check({tag, "_flush_rises"}, a_rises_hi - h0, FLUSH_RISES);
    check({tag, "_gap"}, gap, GAP_A);
  endtask

  typedef struct {
    string       tag;
    logic [31:0] word;
    logic [31:0] late;
    logic [31:0] exp_word;
  } vec_t;

  vec_t vecs [4];

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int f0, d0, rl0, rc, n, gap;
    logic ps;

    vecs[0] = '{"v_a5c3", 32'hA5C3_0F81, 32'hA5C3_0F81, 32'hA5C3_0F81};
    vecs[1] = '{"v_late", 32'hDEAD_BEEF, 32'h1234_5678, 32'hDEAD_BEEF};
    vecs[2] = '{"v_8001", 32'h8000_0001, 32'h8000_0001, 32'h8000_0001};
    vecs[3] = '{"v_zero", 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000};

    // Reset values, with tx_valid asserted during reset.
    a_valid = 1'b1; a_data = 32'h1111_2222;
    repeat (3) @(negedge clk);
    check("rst_ss", a_ss, 1);
    check("rst_sclk", a_sclk, 0);
    check("rst_mosi", a_mosi, 0);
    check("rst_ready", a_ready, 1);
    check("rst_busy", a_busy, 0);
    check("rst_done", a_done, 0);
    check("rst_b_ss", b_ss, 1);
    a_valid = 1'b0;
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_valid_ignored_frames", a_frames, 0);
    check("rst_valid_ignored_busy", a_busy, 0);

    // Single frames from the table.
    for (int i = 0; i < 4; i++) begin
      frame_a(vecs[i].tag, vecs[i].word, vecs[i].late, vecs[i].exp_word);
    end

    // Back-to-back: tx_valid held high across two words.
    @(negedge clk);
    f0 = a_frames; rl0 = a_rdy_lo;
    a_data = 32'hFFFF_FFFF; a_valid = 1'b1;
    @(posedge clk); #1;
    a_data = 32'h0000_0001;
    @(negedge clk);
    wait_ready_a("b2b_second");
    @(posedge clk); #1;
    a_valid = 1'b0;
    @(negedge clk);
    finish_frame_a("b2b", gap);
    check("b2b_frames", a_frames - f0, 2);
    check("b2b_word1", a_prev_word, 32'hFFFF_FFFF);
    check("b2b_word2", a_last_word, 32'h0000_0001);
    check("b2b_len1", a_prev_len, LEN_A);
    check("b2b_len2", a_last_len, LEN_A);
    // SS stays high for the GAP plus the IDLE cycle in which the next word is accepted.
    check("b2b_ss_high", a_last_gap, GAP_A + 1);
    check("b2b_ready_low_in_frames", a_rdy_lo - rl0, 0);

    // Reset asserted at the tenth SCLK rise drops the word without a done pulse.
    @(negedge clk);
    d0 = a_dones;
    a_data = 32'hC0DE_F00D; a_valid = 1'b1;
    @(posedge clk); #1;
    a_valid = 1'b0;
    rc = 0; n = 0; ps = a_sclk;
    while (rc < 10 && n < 600) begin
      @(negedge clk);
      n++;
      if (a_sclk && !ps) rc++;
      ps = a_sclk;
    end
    check("mid_rst_reached_rise10", rc, 10);
    reset = 1'b1;
    #1;
    check("mid_rst_ss", a_ss, 1);
    check("mid_rst_sclk", a_sclk, 0);
    check("mid_rst_mosi", a_mosi, 0);
    check("mid_rst_ready", a_ready, 1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("mid_rst_no_done", a_dones - d0, 0);
    frame_a("after_rst", 32'h0000_00FF, 32'h0000_00FF, 32'h0000_00FF);

    // Instance B: CLK_DIV=1, 8-bit word.
    @(negedge clk);
    d0 = b_dones; rc = b_rises;
    b_data = 8'h5A; b_valid = 1'b1;
    @(posedge clk); #1;
    b_valid = 1'b0;
    @(negedge clk);
    n = 0;
    while (!b_ss && n < 200) begin @(negedge clk); n++; end
    check("b_ss_rise", b_ss, 1);
    gap = 0;
    while (!b_ready && gap < 100) begin @(negedge clk); gap++; end
    @(negedge clk);
    check("b_ss_len", b_last_len, 20);
    check("b_word", b_last_word, 8'h5A);
    check("b_rises", b_rises - rc, 8);
    check("b_sclk_period", b_last_period, 2);
    check("b_done", b_dones - d0, 1);
    check("b_gap", gap, GAP_B);

    check("a_mosi_low_while_ss_high", a_mosi_hi, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
